fetch_unit: RTL
===============

# fetch_unit

Clocked, parametrised instruction-fetch unit for the multicycle MIPS core. It replaces the single-shot fetch step with a free-running prefetcher. It issues sequential word reads to instruction memory over a valid/ready handshake and buffers returned instructions with their PCs in a DEPTH-entry queue. It presents the head of the queue to decode. A branch or jump redirect flushes the queue and discards any in-flight read.

## Interface
- WORD_SIZE, 32: instruction, address and PC width.
- DEPTH, 4: prefetch queue entries; power of two, ≥ 2.
- RESET_PC, 0: PC loaded on reset.
- PC_STEP, 4: sequential PC increment.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_on  out  1  read request valid.
- mem_w  out  1  write enable; constant 0.
- mem_addr  out  WORD_SIZE  read address; stable while mem_on=1 and not yet accepted.
- mem_ready  in  1  memory completes current read this cycle; mem_data_out valid.
- mem_data_out  in  WORD_SIZE  read data.
- redirect_valid  in  1  load new PC, flush.
- redirect_pc  in  WORD_SIZE  redirect target.
- ir_valid  out  1  queue non-empty.
- ir_data  out  WORD_SIZE  head instruction; 0 when empty.
- ir_pc  out  WORD_SIZE  PC of head instruction; 0 when empty.
- ir_ready  in  1  decode consumes head when ir_valid=1.
- fifo_count  out  $clog2(DEPTH+1)  entries held.

## Operation
- Reset values: mem_on=0, mem_w=0, mem_addr=0, ir_valid=0, ir_data=0, ir_pc=0, fifo_count=0. Internal pc=RESET_PC, state=IDLE.
- The unit allows one outstanding read. The read completes on an edge where mem_on=1 and mem_ready=1. mem_ready with mem_on=0 is ignored.
- The unit issues a read only if fifo_count_next + 1 ≤ DEPTH. fifo_count_next includes this cycle's push and pop. The queue therefore never overflows, and a returning read always has a slot.
- FSM states:
  - IDLE: mem_on=0. If there is no redirect and there is space, go to REQ with mem_addr←pc, pc←pc+PC_STEP.
  - REQ: mem_on=1, awaiting mem_ready.
    - On completion without redirect: push {mem_data_out, mem_addr}. If there is space, stay in REQ with the next address (back-to-back). Otherwise go to IDLE.
    - On redirect before or at completion: see the flush rules below.
  - DISCARD: mem_on=1, mem_addr held at the old address. When mem_ready arrives, drop the data and go to IDLE.
- Redirect (redirect_valid=1 at an edge), which has priority over everything else:
  - The queue empties and fifo_count←0. A pop or push in the same cycle is ignored.
  - pc←redirect_pc.
  - From IDLE: stay in IDLE; the request at redirect_pc issues on the following edge.
  - From REQ without mem_ready: go to DISCARD.
  - From REQ with mem_ready in the same cycle: the data is dropped; go to IDLE.
  - From DISCARD: stay in DISCARD; the newer redirect_pc overwrites pc.
- Pop: when ir_valid && ir_ready, the head advances. A simultaneous push and pop leaves fifo_count unchanged.
- Arithmetic: PC increments modulo 2^WORD_SIZE; 0xFFFFFFFC+4 wraps to 0 silently. Queue pointers wrap modulo DEPTH.
- rst during any state, including REQ or DISCARD, returns to the reset values at that edge. The outstanding read is abandoned, and a later mem_ready is ignored because mem_on=0.

## Timing
- All outputs are registered. ir_data and ir_pc are driven from the head entry, gated to 0 when the queue is empty.
- With zero-wait memory (mem_ready tied to 1):
  - The first mem_on=1 appears 1 cycle after rst deasserts.
  - The first ir_valid=1 appears 1 cycle after that.
  - Sustained throughput is 1 instruction per cycle while ir_ready=1.
- Redirect-to-request latency:
  - From IDLE or REQ: 2 edges. The redirect edge flushes; the next edge drives mem_addr=redirect_pc.
  - From DISCARD: 2 edges plus the remaining wait for mem_ready.
- Latency from a completed read to ir_valid is 1 edge.
- ir_valid never depends combinationally on ir_ready.

## Test plan
- Reset, then stream with mem_ready=1 and ir_ready=1: mem_addr sequence is 0,4,8,…; ir_pc/ir_data pairs match memory; steady state is 1 instruction per cycle; mem_w always 0.
- Back-pressure with ir_ready=0 and DEPTH=4: exactly 4 reads complete, fifo_count=4, and mem_on drops. Raising ir_ready resumes issue 1 cycle after the first pop.
- Wait states with mem_ready high every 3rd cycle: mem_addr stays stable throughout each wait, and no instruction is lost or duplicated.
- Redirect during a waiting read: redirect to 0x100 while REQ addr=0x8 is waiting. The unit enters DISCARD and the 0x8 data is dropped. Next mem_addr=0x100, queue is empty meanwhile, and the first ir_pc=0x100.
- Corner cases:
  - Redirect coinciding with mem_ready: the data is dropped.
  - Redirect with a pop in the same cycle: the queue is empty afterwards.
  - Redirect to 0xFFFFFFFC: the next address wraps to 0x0.
  - rst asserted in REQ: outputs return to reset values next edge, and a later mem_ready is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Prefetching instruction-fetch unit: issues sequential word reads over a
// valid/ready handshake, buffers {instruction, pc} pairs in a DEPTH-entry
// queue and presents the head to decode. A redirect flushes the queue and
// discards any in-flight read.
module fetch_unit #(
    parameter int unsigned          WORD_SIZE = 32,
    parameter int unsigned          DEPTH     = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
    parameter logic [WORD_SIZE-1:0] PC_STEP   = WORD_SIZE'(4)
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         mem_on,
    output logic                         mem_w,
    output logic [WORD_SIZE-1:0]         mem_addr,
    input  logic                         mem_ready,
    input  logic [WORD_SIZE-1:0]         mem_data_out,
    input  logic                         redirect_valid,
    input  logic [WORD_SIZE-1:0]         redirect_pc,
    output logic                         ir_valid,
    output logic [WORD_SIZE-1:0]         ir_data,
    output logic [WORD_SIZE-1:0]         ir_pc,
    input  logic                         ir_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [CntW-1:0]      cnt_flow;
    logic                 push, pop, space;

    logic [WORD_SIZE-1:0] data_q [DEPTH];
    logic [WORD_SIZE-1:0] pcs_q  [DEPTH];

    // Queue bookkeeping: push/pop qualification and next occupancy.
    always_comb begin
        push     = (state_q == StReq) && mem_ready && !redirect_valid;
        pop      = (cnt_q != '0) && ir_ready && !redirect_valid;
        cnt_flow = cnt_q + CntW'(push) - CntW'(pop);
        // A new read is only issued if its data is guaranteed a slot.
        space    = 32'(cnt_flow) < DEPTH;
        cnt_d    = redirect_valid ? '0 : cnt_flow;
        wr_ptr_d = redirect_valid ? '0 : wr_ptr_q + PtrW'(push);
        rd_ptr_d = redirect_valid ? '0 : rd_ptr_q + PtrW'(pop);
    end

    // Next-state logic for the request FSM and the fetch PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        case (state_q)
            StIdle: begin
                if (!redirect_valid && space) begin
                    state_d = StReq;
                    addr_d  = pc_q;
                    pc_d    = pc_q + PC_STEP;
                end
            end
            StReq: begin
                if (redirect_valid) begin
                    // A read completing on the redirect edge is simply dropped.
                    state_d = mem_ready ? StIdle : StDiscard;
                end else if (mem_ready) begin
                    if (space) begin
                        addr_d = pc_q;
                        pc_d   = pc_q + PC_STEP;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDiscard: begin
                // Address is held until the stale read finishes.
                if (mem_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Queue storage; contents are qualified by the occupancy count.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            data_q[wr_ptr_q] <= mem_data_out;
            pcs_q[wr_ptr_q]  <= addr_q;
        end
    end

    assign mem_on     = (state_q != StIdle);
    assign mem_w      = 1'b0;
    assign mem_addr   = addr_q;
    assign fifo_count = cnt_q;
    assign ir_valid   = (cnt_q != '0);
    assign ir_data    = ir_valid ? data_q[rd_ptr_q] : '0;
    assign ir_pc      = ir_valid ? pcs_q[rd_ptr_q] : '0;

endmodule
